// File: rtl/soc_keycode_fifo_if.sv
// soc_keycode_fifo_if: Avalon-MM slave bus plus keycode valid/ready stream
interface soc_keycode_fifo_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;
    logic [DATA_W-1:0] key_data;
    logic              key_valid;
    logic              key_ready;

    modport master (
        output address, chipselect, write_n, writedata, key_ready,
        input  readdata, irq, key_data, key_valid
    );

    modport slave (
        input  address, chipselect, write_n, writedata, key_ready,
        output readdata, irq, key_data, key_valid
    );
endinterface

// File: rtl/soc_keycode_fifo.sv
// soc_keycode_fifo: software-written keycode FIFO delivered to fabric over valid/ready
module soc_keycode_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int LOW_WM = 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    soc_keycode_fifo_if.slave bus,
    output logic [DATA_W-1:0] out_port
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] out_port_q, out_port_d;
    logic              irq_q, irq_d;
    logic              wr, push_req, flush, ovf_clr, empty, full, pop, push_ok, push_drop;
    logic [31:0]       status;
    logic              unused_wd;

    assign unused_wd = ^bus.writedata;

    // Decode bus writes and stream handshake; count alone tracks full/empty.
    always_comb begin
        wr        = bus.chipselect & ~bus.write_n;
        push_req  = wr & (bus.address == 2'd0);
        flush     = wr & (bus.address == 2'd1) & bus.writedata[31];
        ovf_clr   = wr & (bus.address == 2'd1) & bus.writedata[18];
        empty     = count_q == '0;
        full      = count_q == CNT_W'(DEPTH);
        pop       = ~empty & bus.key_ready;
        push_ok   = push_req & ~flush & (~full | pop);
        push_drop = push_req & ~flush & full & ~pop;
        count_d    = flush ? '0 : count_q + CNT_W'(push_ok) - CNT_W'(pop);
        rd_ptr_d   = flush ? '0 : rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = flush ? '0 : wr_ptr_q + PTR_W'(push_ok);
        ovf_d      = push_drop | (ovf_q & ~ovf_clr);
        ctrl_d     = (wr & (bus.address == 2'd2)) ? bus.writedata[1:0] : ctrl_q;
        out_port_d = pop ? bus.key_data : out_port_q;
        irq_d      = (ctrl_d[0] & (count_d <= CNT_W'(LOW_WM))) | (ctrl_d[1] & ovf_d);
    end

    // Control and status state; everything clears asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            ctrl_q     <= '0;
            out_port_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            ctrl_q     <= ctrl_d;
            out_port_q <= out_port_d;
            irq_q      <= irq_d;
        end
    end

    // Storage array is not reset; a full-FIFO push overwrites the slot popped this edge.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.writedata[DATA_W-1:0];
    end

    // Head-of-FIFO stream and zero-wait-state register readback.
    always_comb begin
        bus.key_valid = ~empty;
        bus.key_data  = empty ? '0 : mem_q[rd_ptr_q];
        bus.irq       = irq_q;
        out_port      = out_port_q;
        status        = 32'(count_q);
        status[16]    = empty;
        status[17]    = full;
        status[18]    = ovf_q;
        bus.readdata  = (bus.address == 2'd0) ? 32'(bus.key_data) :
                        (bus.address == 2'd1) ? status :
                        (bus.address == 2'd2) ? {30'b0, ctrl_q} : 32'(out_port_q);
    end
endmodule

// File: tb/tb_soc_keycode_fifo.sv
// tb_soc_keycode_fifo: directed and random checks against a queue-based model
module tb_soc_keycode_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int LOW_WM = 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] out_port;

    soc_keycode_fifo_if #(.DATA_W(DATA_W)) kif ();

    soc_keycode_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LOW_WM(LOW_WM)) dut (
        .clk(clk), .reset_n(reset_n), .bus(kif.slave), .out_port(out_port)
    );

    always #5 clk = ~clk;

    int       q[$];
    bit       m_ovf;
    bit [1:0] m_ctrl;
    int       m_last;
    bit       m_irq;
    int       n_pass, n_chk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        q.delete();
        m_ovf  = 0;
        m_ctrl = 0;
        m_last = 0;
        m_irq  = 0;
    endfunction

    function automatic void model_step(bit wr, logic [1:0] a, logic [31:0] d, bit kr);
        bit set = 0;
        if (kr && q.size() > 0) begin
            m_last = q[0];
            void'(q.pop_front());
        end
        if (wr && a == 2'd1 && d[31]) q.delete();
        else if (wr && a == 2'd0) begin
            if (q.size() < DEPTH) q.push_back(int'(d) & ((1 << DATA_W) - 1));
            else set = 1;
        end
        m_ovf = set | (m_ovf & !(wr && a == 2'd1 && d[18]));
        if (wr && a == 2'd2) m_ctrl = d[1:0];
        m_irq = (m_ctrl[0] && q.size() <= LOW_WM) || (m_ctrl[1] && m_ovf);
    endfunction

    function automatic logic [31:0] exp_rd(int a);
        case (a)
            0: return (q.size() > 0) ? 32'(q[0]) : 32'd0;
            1: return 32'(q.size()) | (32'(q.size() == 0) << 16) |
                      (32'(q.size() == DEPTH) << 17) | (32'(m_ovf) << 18);
            2: return 32'(m_ctrl);
            default: return 32'(m_last);
        endcase
    endfunction

    task automatic check_all(input string tag);
        chk({tag, " valid"}, 32'(kif.key_valid), 32'(q.size() > 0));
        chk({tag, " data"}, 32'(kif.key_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        chk({tag, " irq"}, 32'(kif.irq), 32'(m_irq));
        chk({tag, " out_port"}, 32'(out_port), 32'(m_last));
        for (int a = 0; a < 4; a++) begin
            kif.address = 2'(a);
            #1;
            chk($sformatf("%s rd%0d", tag, a), kif.readdata, exp_rd(a));
        end
    endtask

    task automatic tick();
        model_step(kif.chipselect & ~kif.write_n, kif.address, kif.writedata, kif.key_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d, input bit kr, input string tag);
        kif.address    = a;
        kif.writedata  = d;
        kif.chipselect = 1'b1;
        kif.write_n    = 1'b0;
        kif.key_ready  = kr;
        tick();
        kif.chipselect = 1'b0;
        kif.write_n    = 1'b1;
        kif.key_ready  = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input bit kr, input string tag);
        kif.key_ready = kr;
        tick();
        kif.key_ready = 1'b0;
        check_all(tag);
    endtask

    int       op;
    bit       kr;
    logic [31:0] d;

    initial begin
        kif.address    = '0;
        kif.chipselect = 1'b0;
        kif.write_n    = 1'b1;
        kif.writedata  = '0;
        kif.key_ready  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        wr_reg(0, 32'h1C, 0, "push1C");
        wr_reg(0, 32'h32, 0, "push32");
        wr_reg(0, 32'h23, 0, "push23");
        repeat (3) idle(1, "drain3");
        chk("last23", 32'(out_port), 32'h23);

        for (int i = 0; i < 9; i++) wr_reg(0, 32'(8'h60 + i), 0, "fill9");
        wr_reg(1, 32'h40000, 0, "ovfclr");

        wr_reg(0, 32'h44, 1, "pushpop_full");
        for (int i = 0; i < DEPTH; i++) idle(1, "drain8");
        chk("last44", 32'(out_port), 32'h44);

        wr_reg(2, 32'h1, 0, "ctrl_wm");
        wr_reg(0, 32'h11, 0, "wm_push");
        wr_reg(0, 32'h12, 0, "wm_push");
        idle(1, "wm_pop");
        wr_reg(2, 32'h2, 0, "ctrl_ovf");
        for (int i = 0; i < DEPTH + 1; i++) wr_reg(0, 32'(8'h70 + i), 0, "ovf_fill");
        wr_reg(1, 32'h40000, 0, "ovfclr2");
        wr_reg(0, 32'h55, 0, "ovf_again");
        wr_reg(1, 32'h8000_0000, 1, "flush_pop");

        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            kr = 1'($urandom_range(0, 1));
            d  = $urandom;
            if (op < 5) wr_reg(0, d, kr, "rnd_push");
            else if (op == 5) wr_reg(1, d & (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'h7FFF_FFFF), kr, "rnd_stat");
            else if (op == 6) wr_reg(2, d, kr, "rnd_ctrl");
            else if (op == 7) wr_reg(3, d, kr, "rnd_last");
            else idle(kr, "rnd_idle");
        end

        wr_reg(2, 32'h3, 0, "pre_rst");
        wr_reg(0, 32'hA5, 0, "pre_rst");
        idle(1, "pre_rst");
        wr_reg(0, 32'h5A, 0, "pre_rst");
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wr_reg(0, 32'h3C, 0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
